// File: rtl/calc_pkg.sv
// Shared calculator types: result width, result word type and opcode encoding.
package calc_pkg;

    localparam int DATA_W = 17;

    typedef logic [DATA_W-1:0] calc_word_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_e;

endpackage

// File: rtl/calc_result_buffer_if.sv
// Producer-side capture and consumer-side valid/ready handshake of the result buffer.
interface calc_result_buffer_if #(
    parameter int DATA_W = calc_pkg::DATA_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_zero
    );

endinterface

// File: rtl/calc_res_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module calc_res_ram #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    // Storage is deliberately not reset; the owner masks stale entries.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/calc_result_buffer.sv
// Result FIFO behind the calculator; never back-pressures its producer, flags dropped words.
// Optional statistics (max/min/count of accepted words) enabled by CALC_RES_STATS_EN.
module calc_result_buffer
    import calc_pkg::*;
#(
    parameter int DATA_W = calc_pkg::DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    calc_result_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr
`ifdef CALC_RES_STATS_EN
    ,
    output logic [DATA_W-1:0]      stat_max,
    output logic [DATA_W-1:0]      stat_min,
    output logic [15:0]            stat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, drop, nonempty;
    logic [DATA_W-1:0] rd_data;

    assign nonempty = (level_q != '0);
    assign full     = (level_q == FULL_LVL);
    assign pop      = nonempty & bus.out_ready;
    assign push     = bus.in_valid & (~full | pop);
    assign drop     = bus.in_valid & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A fresh drop outranks a clear in the same cycle.
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    calc_res_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign bus.out_valid = nonempty;
    assign bus.out_data  = nonempty ? rd_data : '0;
    assign bus.out_zero  = nonempty & (rd_data == '0);
    assign level         = level_q;
    assign overflow      = ovf_q;

`ifdef CALC_RES_STATS_EN
    logic [DATA_W-1:0] stat_max_q, stat_min_q;
    logic [15:0]       stat_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_max_q <= '0;
            stat_min_q <= '1;
            stat_cnt_q <= '0;
        end else if (ovf_clr) begin
            stat_max_q <= '0;
            stat_min_q <= '1;
            stat_cnt_q <= '0;
        end else if (push) begin
            if (bus.in_data > stat_max_q) stat_max_q <= bus.in_data;
            if (bus.in_data < stat_min_q) stat_min_q <= bus.in_data;
            if (stat_cnt_q != 16'hFFFF)   stat_cnt_q <= stat_cnt_q + 16'd1;
        end
    end

    assign stat_max = stat_max_q;
    assign stat_min = stat_min_q;
    assign stat_cnt = stat_cnt_q;
`endif

endmodule
